byte_uart_tx: RTL and testbench
===============================

Name: byte_uart_tx

Overview:
- Serial output stage downstream of the 8-bit counter block.
- Accepts bytes (for example, counter snapshots) over a valid/ready handshake and buffers them in a small FIFO.
- Serialises each byte as 8N1 UART frames on one IO pin, so the board host can log the count stream.
- Fixed baud divider per build; no receive path.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit. Legal values are 2 or more.
- FIFO_DEPTH, 4, entries in the input FIFO. Must be a power of 2, 2 or more.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_data  input  8  byte to transmit.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  FIFO can accept a byte this cycle.
- tx  output  1  UART serial line; idle high; registered.
- busy  output  1  high while a frame is in progress (START, DATA or STOP state); registered.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  number of bytes currently queued, excluding the byte being shifted.

Behaviour:
- Reset (rst_n low at an edge):
  - tx=1, busy=0, fifo_count=0.
  - FSM goes to IDLE; bit counter and baud counter are cleared.
  - FIFO pointers are cleared; contents are discarded.
  - in_ready=0 while rst_n is low.
- Reset mid-frame aborts the frame: tx=1 from the next edge, and no partial bits resume.
- Handshake:
  - Push occurs when in_valid and in_ready are both high at a rising edge.
  - in_ready = (fifo_count < FIFO_DEPTH) and rst_n. It is combinational from registered count.
  - When full, in_ready=0 even if a pop happens in the same cycle. There is no write-through at full.
  - in_data is ignored when in_valid=0. Nothing is ever dropped.
- FIFO:
  - Circular buffer with wrapping read/write pointers.
  - Simultaneous push and pop leaves fifo_count unchanged, and data order is preserved.
- FSM states are IDLE, START, DATA, STOP.
  - IDLE: tx=1, busy=0. If fifo_count>0, pop the head into the shift register and go to START. The pop is visible in fifo_count after the same edge.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0], LSB first. Each bit is held CLKS_PER_BIT cycles, then the register shifts right and the index increments. After bit 7 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
    - On the last STOP cycle, if fifo_count>0, pop and go directly to START (back-to-back frames, no idle gap).
    - Otherwise go to IDLE.
- Timing:
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
  - A push at edge N into an empty, idle block gives a pop at edge N+1. tx falls after edge N+1.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and reloads 0 on every state or bit transition.
  - Width is $clog2(CLKS_PER_BIT).
- Glitch-free line: tx changes only at bit boundaries and is driven from a flop.

Test Plan:
- Reset state: hold rst_n=0 for 3 cycles with in_valid=1 and in_data=0xFF -> tx=1, busy=0, fifo_count=0, in_ready=0 throughout. After release, in_ready=1 and nothing is queued.
- Single frame (CLKS_PER_BIT=4): push 0xA5 at edge N.
  - tx falls after edge N+1.
  - Bit sequence is 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), each held exactly 4 cycles.
  - busy=1 for 40 cycles, then 0.
- Fill/backpressure (CLKS_PER_BIT=4, FIFO_DEPTH=4): drive in_valid=1 continuously with bytes 0x01..0x06.
  - 0x01 pops at edge 1; fifo_count reaches 4 after edge 4 (0x02..0x05 queued), so 5 bytes are accepted.
  - in_ready=0 until the pop at the end of the 0x01 frame.
  - 0x06 is accepted the edge after that pop.
  - Frames 0x01..0x06 appear back-to-back with no idle cycles.
- Simultaneous push/pop at count=2: push coinciding with the STOP-end pop -> fifo_count stays 2, and the serial order matches push order.
- Reset mid-frame: assert rst_n=0 during DATA bit 3 of 0x3C with 2 bytes queued.
  - Next edge: tx=1, busy=0, fifo_count=0.
  - After release, no further frames appear until a new push.
- Divider corner (CLKS_PER_BIT=2): push 0x00 then 0xFF -> each bit lasts exactly 2 cycles, total 40 cycles, stop bits high, no gap between frames.

Source files
------------

// File: rtl/byte_uart_tx.sv
// byte_uart_tx: buffers bytes from a valid/ready port in a small circular FIFO
// and shifts each one out as an 8N1 UART frame (start, 8 data LSB first, stop).
// The baud rate is fixed at build time by CLKS_PER_BIT; there is no receiver.
module byte_uart_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [7:0]                  in_data,
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic                        tx,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t        r_state;
   state_t        w_state_next;
   logic [BW-1:0] r_baud;
   logic [2:0]    r_bit;
   logic [7:0]    r_shift;
   logic [7:0]    w_shift_next;
   logic          r_tx;
   logic          w_tx_next;
   logic          r_busy;
   logic          w_busy_next;
   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_push;
   logic          w_pop;
   logic          w_baud_done;
   logic          w_bit_last;

   // Ready comes only from the registered count, so a pop at full cannot
   // open a same-cycle write slot.
   assign in_ready    = (r_count < COUNT_FULL) && rst_n;
   assign w_push      = in_valid && in_ready;
   assign w_baud_done = (r_baud == BAUD_LAST);
   assign w_bit_last  = (r_bit == 3'd7);

   assign tx         = r_tx;
   assign busy       = r_busy;
   assign fifo_count = r_count;

   // FIFO storage; contents are don't-care until pointed at, so no reset
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= in_data;
   end

   // FIFO pointers (wrap naturally, depth is a power of 2) and occupancy
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   // Next-state logic; a pop happens when leaving IDLE or at the end of STOP
   always_comb begin
      w_state_next = r_state;
      w_pop        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_count != '0) begin
               w_pop        = 1'b1;
               w_state_next = S_START;
            end
         end
         S_START: begin
            if (w_baud_done) w_state_next = S_DATA;
         end
         S_DATA: begin
            if (w_baud_done && w_bit_last) w_state_next = S_STOP;
         end
         S_STOP: begin
            if (w_baud_done) begin
               if (r_count != '0) begin
                  w_pop        = 1'b1;
                  w_state_next = S_START;
               end else begin
                  w_state_next = S_IDLE;
               end
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Output logic: next shift value and the line level for the upcoming state
   always_comb begin
      w_shift_next = r_shift;
      if (w_pop) begin
         w_shift_next = r_mem[r_rd_ptr];
      end else if ((r_state == S_DATA) && w_baud_done) begin
         w_shift_next = {1'b0, r_shift[7:1]};
      end
      w_tx_next = 1'b1;
      case (w_state_next)
         S_START: w_tx_next = 1'b0;
         S_DATA:  w_tx_next = w_shift_next[0];
         default: w_tx_next = 1'b1;
      endcase
      w_busy_next = (w_state_next != S_IDLE);
   end

   // Baud and bit counters restart on every state or bit transition
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_baud <= '0;
         r_bit  <= '0;
      end else begin
         if ((r_state == S_IDLE) || w_baud_done) r_baud <= '0;
         else                                     r_baud <= r_baud + 1'b1;
         if (r_state != S_DATA) r_bit <= '0;
         else if (w_baud_done)  r_bit <= r_bit + 1'b1;
      end
   end

   // Shift register is pure datapath; it is loaded before it is ever observed
   always_ff @(posedge clk) begin
      r_shift <= w_shift_next;
   end

   // Registered line and busy flag so tx only moves on bit boundaries
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_tx   <= 1'b1;
         r_busy <= 1'b0;
      end else begin
         r_tx   <= w_tx_next;
         r_busy <= w_busy_next;
      end
   end

endmodule

// File: tb/tb_byte_uart_tx.sv
// Bench for byte_uart_tx: one instance at 4 clocks/bit, one at 2 clocks/bit.
module tb_byte_uart_tx;

   typedef struct {
      logic [7:0] data;
      logic [9:0] frame;   // line levels in send order, bit 0 first
   } vec_t;

   logic       clk;
   logic       rst_n;
   logic [7:0] id_a, id_b;
   logic       iv_a, iv_b;
   logic       rdy_a, rdy_b;
   logic       tx_a, tx_b;
   logic       busy_a, busy_b;
   logic [2:0] cnt_a, cnt_b;

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;

   vec_t singles [4];
   vec_t fill_v  [6];
   vec_t sim_v   [4];
   vec_t div_v   [2];

   byte_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .in_data(id_a), .in_valid(iv_a),
      .in_ready(rdy_a), .tx(tx_a), .busy(busy_a), .fifo_count(cnt_a));

   byte_uart_tx #(.CLKS_PER_BIT(2), .FIFO_DEPTH(4)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .in_data(id_b), .in_valid(iv_b),
      .in_ready(rdy_b), .tx(tx_b), .busy(busy_b), .fifo_count(cnt_b));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Starts on the sample right after the pop edge; ends on the sample
   // 10*cpb edges later.
   task automatic check_frame(input bit sel, input logic [9:0] bits, input int cpb, input string tag);
      logic [9:0] b;
      b = bits;
      for (int k = 0; k < 10 * cpb; k++) begin
         chk($sformatf("%s_tx_k%0d", tag, k), 32'(sel ? tx_b : tx_a), 32'(b[k / cpb]));
         chk($sformatf("%s_busy_k%0d", tag, k), 32'(sel ? busy_b : busy_a), 32'd1);
         tick();
      end
   endtask

   initial begin : main
      int c0;
      int bad;
      int acc_cyc [6];

      singles[0] = '{8'hA5, 10'h34A};
      singles[1] = '{8'h3C, 10'h278};
      singles[2] = '{8'h81, 10'h302};
      singles[3] = '{8'h7E, 10'h2FC};
      fill_v[0]  = '{8'h01, 10'h202};
      fill_v[1]  = '{8'h02, 10'h204};
      fill_v[2]  = '{8'h03, 10'h206};
      fill_v[3]  = '{8'h04, 10'h208};
      fill_v[4]  = '{8'h05, 10'h20A};
      fill_v[5]  = '{8'h06, 10'h20C};
      sim_v[0]   = '{8'h11, 10'h222};
      sim_v[1]   = '{8'h22, 10'h244};
      sim_v[2]   = '{8'h33, 10'h266};
      sim_v[3]   = '{8'h44, 10'h288};
      div_v[0]   = '{8'h00, 10'h200};
      div_v[1]   = '{8'hFF, 10'h3FE};

      // Reset held with a byte offered
      rst_n = 1'b0;
      iv_a = 1'b1; id_a = 8'hFF;
      iv_b = 1'b1; id_b = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("rst%0d_tx", i),    32'(tx_a),   32'd1);
         chk($sformatf("rst%0d_busy", i),  32'(busy_a), 32'd0);
         chk($sformatf("rst%0d_count", i), 32'(cnt_a),  32'd0);
         chk($sformatf("rst%0d_ready", i), 32'(rdy_a),  32'd0);
         chk($sformatf("rst%0d_count_b", i), 32'(cnt_b), 32'd0);
      end
      rst_n = 1'b1;
      iv_a = 1'b0; iv_b = 1'b0;
      tick();
      chk("rel_ready", 32'(rdy_a),  32'd1);
      chk("rel_count", 32'(cnt_a),  32'd0);
      chk("rel_busy",  32'(busy_a), 32'd0);
      chk("rel_tx",    32'(tx_a),   32'd1);

      // Single frames into an idle block
      for (int v = 0; v < 4; v++) begin
         iv_a = 1'b1; id_a = singles[v].data;
         tick();
         iv_a = 1'b0;
         chk($sformatf("s%0d_push_count", v), 32'(cnt_a),  32'd1);
         chk($sformatf("s%0d_push_tx", v),    32'(tx_a),   32'd1);
         chk($sformatf("s%0d_push_busy", v),  32'(busy_a), 32'd0);
         tick();
         chk($sformatf("s%0d_pop_count", v), 32'(cnt_a), 32'd0);
         check_frame(1'b0, singles[v].frame, 4, $sformatf("s%0d", v));
         chk($sformatf("s%0d_end_busy", v), 32'(busy_a), 32'd0);
         chk($sformatf("s%0d_end_tx", v),   32'(tx_a),   32'd1);
         tick();
      end

      // Fill and backpressure with in_valid held high
      c0 = cyc;
      fork
         begin : fill_drv
            int  waited;
            bit  acc;
            for (int i = 0; i < 6; i++) begin
               waited = 0;
               acc    = 1'b0;
               id_a = fill_v[i].data;
               iv_a = 1'b1;
               while (!acc && (waited < 200)) begin
                  @(negedge clk);
                  acc = rdy_a;
                  tick();
                  waited++;
               end
               chk($sformatf("fill_accept_%0d", i), 32'(acc), 32'd1);
               acc_cyc[i] = cyc - c0;
            end
            iv_a = 1'b0;
         end
         begin : fill_mon
            tick();
            chk("fill_e0_count", 32'(cnt_a), 32'd1);
            tick();
            chk("fill_e1_count", 32'(cnt_a), 32'd1);
            tick(); tick(); tick();
            chk("fill_e4_count", 32'(cnt_a), 32'd4);
            chk("fill_e4_ready", 32'(rdy_a), 32'd0);
            bad = 0;
            for (int e = 5; e <= 40; e++) begin
               tick();
               if ((rdy_a !== 1'b0) || (cnt_a !== 3'd4)) bad++;
            end
            chk("fill_full_hold", 32'(bad), 32'd0);
            tick();
            chk("fill_e41_count", 32'(cnt_a), 32'd3);
            chk("fill_e41_ready", 32'(rdy_a), 32'd1);
            tick();
            chk("fill_e42_count", 32'(cnt_a), 32'd4);
            chk("fill_e42_ready", 32'(rdy_a), 32'd0);
         end
         begin : fill_frames
            tick(); tick();
            for (int i = 0; i < 6; i++)
               check_frame(1'b0, fill_v[i].frame, 4, $sformatf("fill%0d", i));
            chk("fill_end_busy",  32'(busy_a), 32'd0);
            chk("fill_end_tx",    32'(tx_a),   32'd1);
            chk("fill_end_count", 32'(cnt_a),  32'd0);
         end
      join
      chk("fill_acc01_edge", 32'(acc_cyc[0]), 32'd1);
      chk("fill_acc05_edge", 32'(acc_cyc[4]), 32'd5);
      chk("fill_acc06_edge", 32'(acc_cyc[5]), 32'd43);
      tick(); tick();

      // Push coinciding with the end-of-STOP pop at count 2
      fork
         begin : sim_drv
            iv_a = 1'b1; id_a = sim_v[0].data;
            tick();
            id_a = sim_v[1].data;
            tick();
            id_a = sim_v[2].data;
            tick();
            iv_a = 1'b0;
            for (int e = 3; e <= 40; e++) tick();
            chk("sim_e40_count", 32'(cnt_a), 32'd2);
            iv_a = 1'b1; id_a = sim_v[3].data;
            tick();
            iv_a = 1'b0;
            chk("sim_e41_count", 32'(cnt_a), 32'd2);
         end
         begin : sim_frames
            tick(); tick();
            for (int i = 0; i < 4; i++)
               check_frame(1'b0, sim_v[i].frame, 4, $sformatf("sim%0d", i));
            chk("sim_end_busy", 32'(busy_a), 32'd0);
         end
      join
      tick(); tick();

      // Two clocks per bit, back-to-back 0x00 then 0xFF
      iv_b = 1'b1; id_b = div_v[0].data;
      tick();
      chk("div_e0_count", 32'(cnt_b), 32'd1);
      id_b = div_v[1].data;
      tick();
      iv_b = 1'b0;
      chk("div_e1_count", 32'(cnt_b), 32'd1);
      check_frame(1'b1, div_v[0].frame, 2, "div0");
      check_frame(1'b1, div_v[1].frame, 2, "div1");
      chk("div_end_busy", 32'(busy_b), 32'd0);
      chk("div_end_tx",   32'(tx_b),   32'd1);
      tick(); tick();

      // Reset during DATA bit 3 of 0x3C with two bytes queued
      iv_a = 1'b1; id_a = 8'h3C;
      tick();
      id_a = 8'h55;
      tick();
      id_a = 8'h66;
      tick();
      iv_a = 1'b0;
      for (int e = 3; e <= 18; e++) tick();
      chk("mid_pre_tx",    32'(tx_a),   32'd1);
      chk("mid_pre_busy",  32'(busy_a), 32'd1);
      chk("mid_pre_count", 32'(cnt_a),  32'd2);
      rst_n = 1'b0;
      tick();
      chk("mid_rst_tx",    32'(tx_a),   32'd1);
      chk("mid_rst_busy",  32'(busy_a), 32'd0);
      chk("mid_rst_count", 32'(cnt_a),  32'd0);
      chk("mid_rst_ready", 32'(rdy_a),  32'd0);
      rst_n = 1'b1;
      bad = 0;
      for (int e = 0; e < 60; e++) begin
         tick();
         if ((tx_a !== 1'b1) || (busy_a !== 1'b0) || (cnt_a !== 3'd0)) bad++;
      end
      chk("mid_quiet_after", 32'(bad), 32'd0);
      chk("mid_ready_after", 32'(rdy_a), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
